// File: rtl/simt_banked_regfile.sv
// simt_banked_regfile: banked multi-warp SIMT register file with operand collector
module simt_banked_regfile #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_LANES  = 32,
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_SRC    = 3
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                req_valid,
  output logic                                                req_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]                        req_warp_id,
  input  logic [NUM_SRC-1:0][$clog2(NUM_REGS)-1:0]            req_addr,
  input  logic [NUM_SRC-1:0]                                  req_src_en,
  output logic                                                resp_valid,
  input  logic                                                resp_ready,
  output logic [NUM_SRC-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0]   resp_data,
  input  logic                                                wr_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]                        wr_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]                         wr_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]                wr_data,
  input  logic [NUM_LANES-1:0]                                wr_mask
);
  localparam int WW    = $clog2(NUM_WARPS);
  localparam int AW    = $clog2(NUM_REGS);
  localparam int RPB   = NUM_REGS / NUM_BANKS;
  localparam int DEPTH = NUM_WARPS * RPB;
  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic [1:0] {IDLE, COLLECT, RESP} state_t;
  state_t state, state_nxt;
  row_t mem [NUM_BANKS][DEPTH];
  logic [WW-1:0] warp;
  logic [AW-1:0] addr [NUM_SRC];
  logic [NUM_SRC-1:0] done, grant, zero_slot;
  logic [NUM_BANKS-1:0] claimed;
  logic [AW-1:0] claim_addr [NUM_BANKS];
  row_t rd [NUM_BANKS];
  row_t sd [NUM_SRC];
  logic wr_en;
  // Registers are skewed across banks by warp so the same register of different warps spreads out
  function automatic int bank_of(input logic [WW-1:0] w, input logic [AW-1:0] a);
    return (int'(a) + int'(w)) % NUM_BANKS;
  endfunction
  function automatic int entry_of(input logic [WW-1:0] w, input logic [AW-1:0] a);
    return int'(w) * RPB + int'(a) / NUM_BANKS;
  endfunction
  assign wr_en = wr_valid && wr_addr != '0;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: skip collection when every slot is trivially zero
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) zero_slot[s] = !req_src_en[s] || req_addr[s] == '0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? (&zero_slot ? RESP : COLLECT) : IDLE;
      COLLECT: state_nxt = &(done | grant) ? RESP : COLLECT;
      RESP:    state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // Handshake outputs
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
  end
  // Arbitration in slot order; a slot naming an already-claimed register shares that read
  always_comb begin
    claimed = '0;
    grant   = '0;
    for (int b = 0; b < NUM_BANKS; b++) claim_addr[b] = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (state == COLLECT && !done[s])
        for (int b = 0; b < NUM_BANKS; b++)
          if (bank_of(warp, addr[s]) == b) begin
            if (!claimed[b]) begin
              claimed[b]    = 1'b1;
              claim_addr[b] = addr[s];
              grant[s]      = 1'b1;
            end else if (claim_addr[b] == addr[s]) grant[s] = 1'b1;
          end
  end
  // Bank reads with same-cycle write bypass, then route bank data back to slots
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd[b] = '0;
      for (int e = 0; e < DEPTH; e++)
        if (e == entry_of(warp, claim_addr[b])) rd[b] = mem[b][e];
      if (claimed[b] && wr_en && wr_warp_id == warp && wr_addr == claim_addr[b])
        for (int l = 0; l < NUM_LANES; l++)
          if (wr_mask[l]) rd[b][l] = wr_data[l];
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      sd[s] = '0;
      for (int b = 0; b < NUM_BANKS; b++)
        if (bank_of(warp, addr[s]) == b) sd[s] = rd[b];
    end
  end
  // Request latch and operand capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      warp      <= '0;
      done      <= '0;
      resp_data <= '0;
      for (int s = 0; s < NUM_SRC; s++) addr[s] <= '0;
    end else if (state == IDLE && req_valid) begin
      warp      <= req_warp_id;
      done      <= zero_slot;
      resp_data <= '0;
      for (int s = 0; s < NUM_SRC; s++) addr[s] <= req_addr[s];
    end else if (state == COLLECT)
      for (int s = 0; s < NUM_SRC; s++)
        if (grant[s]) begin
          resp_data[s] <= sd[s];
          done[s]      <= 1'b1;
        end
  // Masked per-lane writeback; x0 writes are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < DEPTH; e++) mem[b][e] <= '0;
    end else if (wr_en)
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < DEPTH; e++)
          if (b == bank_of(wr_warp_id, wr_addr) && e == entry_of(wr_warp_id, wr_addr))
            for (int l = 0; l < NUM_LANES; l++)
              if (wr_mask[l]) mem[b][e][l] <= wr_data[l];
endmodule

// File: tb/tb_simt_banked_regfile.sv
// tb_simt_banked_regfile: directed vectors for the banked register file
module tb_simt_banked_regfile;
  localparam int NL = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_warp_id = '0;
  logic [2:0][4:0] req_addr = '0;
  logic [2:0] req_src_en = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [2:0][31:0][31:0] resp_data;
  logic wr_valid = 1'b0;
  logic [1:0] wr_warp_id = '0;
  logic [4:0] wr_addr = '0;
  logic [31:0][31:0] wr_data = '0;
  logic [31:0] wr_mask = '0;
  logic bp_en = 1'b0;
  logic [1:0] bp_warp = '0;
  logic [4:0] bp_addr = '0;
  logic [31:0] bp_val = '0;
  logic [31:0] bp_mask = '0;
  int n_chk = 0;
  int n_pass = 0;
  int lat = 0;
  always #5 clk = ~clk;
  simt_banked_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_warp_id(req_warp_id),
    .req_addr(req_addr), .req_src_en(req_src_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_warp_id(wr_warp_id), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic write_reg(input logic [1:0] w, input logic [4:0] a, input logic [31:0] base,
                           input logic [31:0] inc, input logic [31:0] mask);
    @(negedge clk);
    wr_valid = 1'b1; wr_warp_id = w; wr_addr = a; wr_mask = mask;
    for (int k = 0; k < NL; k++) wr_data[k] = base + inc * 32'(k);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  task automatic request(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [2:0] en);
    @(negedge clk);
    req_valid = 1'b1; req_warp_id = w; req_addr = {a2, a1, a0}; req_src_en = en;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        req_valid = 1'b0;
        if (bp_en) begin
          wr_valid = 1'b1; wr_warp_id = bp_warp; wr_addr = bp_addr; wr_mask = bp_mask;
          for (int k = 0; k < NL; k++) wr_data[k] = bp_val;
        end
      end else if (lat == 2 && bp_en) begin
        wr_valid = 1'b0;
        bp_en = 1'b0;
      end
    end while (!resp_valid && lat < 20);
  endtask
  task automatic take();
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data[0][0], 32'd0);
    rst_n = 1'b1;
    request(2'd0, 5'd0, 5'd0, 5'd0, 3'b111);
    check("zero_lat", 32'(lat), 32'd1);
    check("zero_data", resp_data[2][5], 32'd0);
    take();
    write_reg(2'd1, 5'd5, 32'd0, 32'd1, 32'hFFFF_FFFF);
    request(2'd1, 5'd5, 5'd6, 5'd7, 3'b111);
    check("cf_lat", 32'(lat), 32'd2);
    check("cf_s0_l0", resp_data[0][0], 32'd0);
    check("cf_s0_l7", resp_data[0][7], 32'd7);
    check("cf_s0_l31", resp_data[0][31], 32'd31);
    check("cf_s1_l3", resp_data[1][3], 32'd0);
    take();
    write_reg(2'd0, 5'd1, 32'h100, 32'd1, 32'hFFFF_FFFF);
    write_reg(2'd0, 5'd5, 32'h500, 32'd1, 32'hFFFF_FFFF);
    write_reg(2'd0, 5'd9, 32'h900, 32'd1, 32'hFFFF_FFFF);
    write_reg(2'd0, 5'd3, 32'h300, 32'd1, 32'hFFFF_FFFF);
    request(2'd0, 5'd1, 5'd5, 5'd9, 3'b111);
    check("conf_lat", 32'(lat), 32'd4);
    check("conf_s0_l2", resp_data[0][2], 32'h102);
    check("conf_s1_l2", resp_data[1][2], 32'h502);
    check("conf_s2_l31", resp_data[2][31], 32'h91F);
    take();
    request(2'd0, 5'd3, 5'd3, 5'd3, 3'b111);
    check("share_lat", 32'(lat), 32'd2);
    check("share_s0_l1", resp_data[0][1], 32'h301);
    check("share_s2_l30", resp_data[2][30], 32'h31E);
    take();
    write_reg(2'd0, 5'd2, 32'hAAAA_AAAA, 32'd0, 32'hFFFF_FFFF);
    bp_en = 1'b1; bp_warp = 2'd0; bp_addr = 5'd2; bp_val = 32'h5555_5555; bp_mask = 32'h0000_FFFF;
    request(2'd0, 5'd2, 5'd0, 5'd0, 3'b001);
    check("byp_lat", 32'(lat), 32'd2);
    check("byp_l0", resp_data[0][0], 32'h5555_5555);
    check("byp_l15", resp_data[0][15], 32'h5555_5555);
    check("byp_l16", resp_data[0][16], 32'hAAAA_AAAA);
    check("byp_l31", resp_data[0][31], 32'hAAAA_AAAA);
    take();
    request(2'd0, 5'd2, 5'd0, 5'd0, 3'b001);
    check("mask_l3", resp_data[0][3], 32'h5555_5555);
    check("mask_l20", resp_data[0][20], 32'hAAAA_AAAA);
    take();
    request(2'd1, 5'd5, 5'd0, 5'd0, 3'b001);
    check("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_data", resp_data[0][4], 32'd4);
    end
    take();
    request(2'd1, 5'd5, 5'd5, 5'd6, 3'b010);
    check("dis_lat", 32'(lat), 32'd2);
    check("dis_s0", resp_data[0][9], 32'd0);
    check("dis_s1", resp_data[1][9], 32'd9);
    take();
    write_reg(2'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
    request(2'd0, 5'd0, 5'd0, 5'd0, 3'b111);
    check("x0_lat", 32'(lat), 32'd1);
    check("x0_data", resp_data[0][0], 32'd0);
    take();
    @(negedge clk);
    req_valid = 1'b1; req_warp_id = 2'd0; req_addr = {5'd9, 5'd5, 5'd1}; req_src_en = 3'b111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    request(2'd0, 5'd1, 5'd5, 5'd9, 3'b111);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_s0", resp_data[0][2], 32'd0);
    check("post_rst_s1", resp_data[1][2], 32'd0);
    check("post_rst_s2", resp_data[2][31], 32'd0);
    take();
    request(2'd1, 5'd5, 5'd0, 5'd0, 3'b001);
    check("post_rst_w1", resp_data[0][7], 32'd0);
    take();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
